// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the 128-bit SRAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam int MEM_DW = 128;
  localparam int MEM_LANES = 16;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h01ff_fff0;
endpackage

// File: rtl/mem_arb_con_snoop.sv
// mem_arb_con_snoop: decodes single-lane console writes into a one-cycle char pulse
module mem_arb_con_snoop import mem_arb_pkg::*; #(
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [MEM_LANES-1:0] wstrb,
  input  logic [MEM_DW-1:0]    wdata,
  output logic                 con_vld,
  output logic [7:0]           con_char
);
  logic       hit;
  logic       lane_ok;
  logic [7:0] ch;
  logic       unused_bits;
  assign unused_bits = ^{addr[3:0], CONSOLE_ADDR[3:0]};
  // only the low byte of a 4-byte word on lane group 0..3 is accepted as a character
  always_comb begin
    lane_ok = wstrb == 16'h000f || wstrb == 16'h00f0 || wstrb == 16'h0f00 || wstrb == 16'hf000;
    ch = wstrb == 16'h000f ? wdata[7:0] :
         wstrb == 16'h00f0 ? wdata[39:32] :
         wstrb == 16'h0f00 ? wdata[71:64] : wdata[103:96];
    hit = acc & we & lane_ok & (addr[31:4] == CONSOLE_ADDR[31:4]);
  end
  // pulse register aligned with the SRAM command cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      con_vld  <= 1'b0;
      con_char <= 8'h00;
    end else begin
      con_vld <= hit;
      if (hit) con_char <= ch;
    end
  end
endmodule

// File: rtl/mem_arb128.sv
// mem_arb128: two-requester burst arbiter and SRAM sequencer (console snoop under MEM_ARB_CONSOLE_EN)
module mem_arb128 import mem_arb_pkg::*; #(
  parameter int          AW = 24,
  parameter int          MAX_HOLD = 16,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_vld,
  output logic                 r0_rdy,
  input  logic [31:0]          r0_addr,
  input  logic                 r0_we,
  input  logic [MEM_LANES-1:0] r0_wstrb,
  input  logic [MEM_DW-1:0]    r0_wdata,
  input  logic                 r0_last,
  output logic                 r0_rvld,
  input  logic                 r1_vld,
  output logic                 r1_rdy,
  input  logic [31:0]          r1_addr,
  input  logic                 r1_we,
  input  logic [MEM_LANES-1:0] r1_wstrb,
  input  logic [MEM_DW-1:0]    r1_wdata,
  input  logic                 r1_last,
  output logic                 r1_rvld,
  output logic [MEM_DW-1:0]    rdata,
  output logic                 mem_cen,
  output logic                 mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [MEM_LANES-1:0] mem_bwen,
  output logic [MEM_DW-1:0]    mem_wdata,
  input  logic [MEM_DW-1:0]    mem_rdata
`ifdef MEM_ARB_CONSOLE_EN
  , output logic               con_vld
  , output logic [7:0]         con_char
`endif
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  state_t               state, nxt;
  logic                 rr, nrr;
  logic [CW-1:0]        cnt;
  logic                 sel, acc, rel, oth_vld;
  logic                 we_m, last_m;
  logic [31:0]          addr_m;
  logic [MEM_LANES-1:0] wstrb_m;
  logic [MEM_DW-1:0]    wdata_m;
  logic                 rd_v, rd_id;
  logic                 unused_bits;
  assign sel     = state == GNT1;
  assign r0_rdy  = state == GNT0;
  assign r1_rdy  = state == GNT1;
  assign acc     = (r0_vld & r0_rdy) | (r1_vld & r1_rdy);
  assign oth_vld = sel ? r0_vld : r1_vld;
  assign we_m    = sel ? r1_we : r0_we;
  assign last_m  = sel ? r1_last : r0_last;
  assign addr_m  = sel ? r1_addr : r0_addr;
  assign wstrb_m = sel ? r1_wstrb : r0_wstrb;
  assign wdata_m = sel ? r1_wdata : r0_wdata;
  assign rel     = acc & (last_m | cnt == CW'(MAX_HOLD - 1));
  assign rdata   = mem_rdata;
  // grant selection: round-robin from IDLE, direct handover to a waiting peer on release
  always_comb begin
    nxt = state;
    nrr = rr;
    if (state == IDLE)
      nxt = r0_vld & r1_vld ? (rr ? GNT1 : GNT0) : r0_vld ? GNT0 : r1_vld ? GNT1 : IDLE;
    else if (rel) begin
      nxt = oth_vld ? (sel ? GNT0 : GNT1) : IDLE;
      nrr = ~sel;
    end
  end
  // grant state, fairness pointer and per-grant beat count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      rr    <= nrr;
      cnt   <= rel ? '0 : acc ? cnt + 1'b1 : cnt;
    end
  end
  // registered SRAM command and read-owner pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cen   <= 1'b1;
      mem_wen   <= 1'b1;
      mem_bwen  <= '1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_v      <= 1'b0;
      rd_id     <= 1'b0;
      r0_rvld   <= 1'b0;
      r1_rvld   <= 1'b0;
    end else begin
      mem_cen  <= ~acc;
      mem_wen  <= ~(acc & we_m);
      mem_bwen <= acc ? ~wstrb_m : '1;
      if (acc) begin
        mem_addr  <= addr_m[AW+3:4];
        mem_wdata <= wdata_m;
      end
      rd_v    <= acc & ~we_m;
      rd_id   <= sel;
      r0_rvld <= rd_v & ~rd_id;
      r1_rvld <= rd_v & rd_id;
    end
  end
`ifdef MEM_ARB_CONSOLE_EN
  assign unused_bits = 1'b0;
  mem_arb_con_snoop #(.CONSOLE_ADDR(CONSOLE_ADDR)) u_snoop (
    .clk(clk), .rst(rst), .acc(acc), .we(we_m), .addr(addr_m),
    .wstrb(wstrb_m), .wdata(wdata_m), .con_vld(con_vld), .con_char(con_char)
  );
`else
  assign unused_bits = ^{addr_m[3:0], addr_m[31:AW+4], CONSOLE_ADDR};
`endif
endmodule

// File: tb/tb_mem_arb128.sv
// tb_mem_arb128: directed self-checking bench for mem_arb128 (console checks under MEM_ARB_CONSOLE_EN)
module tb_mem_arb128;
  logic         clk = 1'b0;
  logic         rst;
  logic         r0_vld, r0_rdy, r0_we, r0_last, r0_rvld;
  logic [31:0]  r0_addr;
  logic [15:0]  r0_wstrb;
  logic [127:0] r0_wdata;
  logic         r1_vld, r1_rdy, r1_we, r1_last, r1_rvld;
  logic [31:0]  r1_addr;
  logic [15:0]  r1_wstrb;
  logic [127:0] r1_wdata;
  logic [127:0] rdata, mem_wdata, mem_rdata;
  logic         mem_cen, mem_wen;
  logic [23:0]  mem_addr;
  logic [15:0]  mem_bwen;
`ifdef MEM_ARB_CONSOLE_EN
  logic         con_vld;
  logic [7:0]   con_char;
`endif
  logic [127:0] sram [0:255];
  logic [127:0] q;
  int npass = 0, nfail = 0, ntot = 0;
  localparam logic [127:0] D  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] A5 = {16{8'ha5}};

  always #5 clk = ~clk;

  mem_arb128 dut (
    .clk(clk), .rst(rst),
    .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wstrb(r0_wstrb), .r0_wdata(r0_wdata), .r0_last(r0_last), .r0_rvld(r0_rvld),
    .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wstrb(r1_wstrb), .r1_wdata(r1_wdata), .r1_last(r1_last), .r1_rvld(r1_rvld),
    .rdata(rdata), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_bwen(mem_bwen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_CONSOLE_EN
    , .con_vld(con_vld), .con_char(con_char)
`endif
  );

  // SRAM model: lane-masked write, one-cycle read latency
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) begin
        for (int k = 0; k < 16; k++)
          if (!mem_bwen[k]) sram[mem_addr[7:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else q <= sram[mem_addr[7:0]];
    end
  end
  assign mem_rdata = q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic w, input logic [15:0] s,
                      input logic [127:0] d, input logic l);
    r0_vld = v; r0_addr = a; r0_we = w; r0_wstrb = s; r0_wdata = d; r0_last = l;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic w, input logic [15:0] s,
                      input logic [127:0] d, input logic l);
    r1_vld = v; r1_addr = a; r1_we = w; r1_wstrb = s; r1_wdata = d; r1_last = l;
  endtask

  initial begin
    rst = 1'b1;
    drv0(0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_r0_rdy", r0_rdy, 0);
    chk("rst_r1_rdy", r1_rdy, 0);
    chk("rst_rvld", {r0_rvld, r1_rvld}, 0);
    chk("rst_cen", mem_cen, 1);
    chk("rst_wen", mem_wen, 1);
    chk("rst_bwen", mem_bwen, 16'hffff);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    step();
    // single-beat write on r0
    drv0(1, 32'h100, 1, 16'hffff, D, 1);
    chk("w1_rdy_idle", r0_rdy, 0);
    step();
    chk("w1_rdy", r0_rdy, 1);
    chk("w1_r1_rdy", r1_rdy, 0);
    chk("w1_cen_pre", mem_cen, 1);
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("w1_cen", mem_cen, 0);
    chk("w1_wen", mem_wen, 0);
    chk("w1_addr", mem_addr, 24'h10);
    chk("w1_bwen", mem_bwen, 16'h0000);
    chk("w1_wdata", mem_wdata, D);
    chk("w1_released", r0_rdy, 0);
    step();
    chk("w1_cen_off", mem_cen, 1);
    // write 0x200 then read it back
    drv0(1, 32'h200, 1, 16'hffff, A5, 1);
    step();
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("w2_addr", mem_addr, 24'h20);
    step();
    drv0(1, 32'h200, 0, 16'h0000, 0, 1);
    step();
    chk("rd_rdy", r0_rdy, 1);
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("rd_cmd_cen", mem_cen, 0);
    chk("rd_cmd_wen", mem_wen, 1);
    chk("rd_rvld_early", r0_rvld, 0);
    step();
    chk("rd_rvld", r0_rvld, 1);
    chk("rd_rdata", rdata, A5);
    chk("rd_r1_rvld", r1_rvld, 0);
    step();
    chk("rd_rvld_off", r0_rvld, 0);
    // simultaneous reads after reset: r0 first, r1 with no bubble
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv0(1, 32'h100, 0, 0, 0, 1);
    drv1(1, 32'h200, 0, 0, 0, 1);
    step();
    chk("rr_r0_first", r0_rdy, 1);
    chk("rr_r1_wait", r1_rdy, 0);
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("rr_r1_next", r1_rdy, 1);
    chk("rr_r0_off", r0_rdy, 0);
    chk("rr_cmd0_addr", mem_addr, 24'h10);
    chk("rr_cmd0_cen", mem_cen, 0);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    chk("rr_cmd1_addr", mem_addr, 24'h20);
    chk("rr_r0_rvld", r0_rvld, 1);
    chk("rr_r0_rdata", rdata, D);
    chk("rr_idle", r1_rdy, 0);
    step();
    chk("rr_r1_rvld", r1_rvld, 1);
    chk("rr_r0_rvld_off", r0_rvld, 0);
    chk("rr_r1_rdata", rdata, A5);
    step();
    // r1 four-beat burst while r0 waits
    drv1(1, 32'h300, 1, 16'hffff, 128'h11, 0);
    step();
    drv0(1, 32'h400, 1, 16'hffff, 128'h22, 1);
    for (int b = 1; b <= 4; b++) begin
      r1_addr = 32'h300 + 32'(16 * (b - 1));
      r1_last = (b == 4);
      chk($sformatf("burst_r0_wait%0d", b), r0_rdy, 0);
      chk($sformatf("burst_r1_own%0d", b), r1_rdy, 1);
      step();
    end
    drv1(0, 0, 0, 0, 0, 0);
    chk("burst_handover", r0_rdy, 1);
    chk("burst_r1_off", r1_rdy, 0);
    chk("burst_last_addr", mem_addr, 24'h33);
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("burst_r0_addr", mem_addr, 24'h40);
    chk("burst_idle", r0_rdy, 0);
    step();
    // r0 20-beat write with r1 pending: forced release after 16 beats
    drv0(1, 32'h1000, 1, 16'hffff, 0, 0);
    step();
    drv1(1, 32'h100, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      r0_addr = 32'h1000 + 32'(16 * i);
      chk($sformatf("hold_r0_beat%0d", i + 1), r0_rdy, 1);
      step();
    end
    chk("hold_r1_granted", r1_rdy, 1);
    chk("hold_r0_released", r0_rdy, 0);
    chk("hold_beat16_addr", mem_addr, 24'h10f);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    chk("hold_r0_regrant", r0_rdy, 1);
    chk("hold_r1_cmd_addr", mem_addr, 24'h10);
    for (int i = 16; i < 20; i++) begin
      r0_addr = 32'h1000 + 32'(16 * i);
      r0_last = (i == 19);
      chk($sformatf("hold_r0_beat%0d", i + 1), r0_rdy, 1);
      step();
    end
    drv0(0, 0, 0, 0, 0, 0);
    chk("hold_done", r0_rdy, 0);
    chk("hold_beat20_addr", mem_addr, 24'h113);
    step();
`ifdef MEM_ARB_CONSOLE_EN
    // console snoop: lane-1 char and a rejected strobe
    drv0(1, 32'h01ff_fff0, 1, 16'h00f0, 128'h41_0000_0000, 1);
    step();
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("con_vld", con_vld, 1);
    chk("con_char", con_char, 8'h41);
    chk("con_sram_cen", mem_cen, 0);
    step();
    chk("con_pulse_end", con_vld, 0);
    drv0(1, 32'h01ff_fff0, 1, 16'h00ff, 128'h42, 1);
    step();
    step();
    drv0(0, 0, 0, 0, 0, 0);
    chk("con_bad_strobe", con_vld, 0);
    step();
`endif
    // reset on beat 2 of a read burst drops everything in flight
    drv0(1, 32'h100, 0, 0, 0, 0);
    step();
    chk("rb_rdy", r0_rdy, 1);
    step();
    chk("rb_beat1_cmd", mem_cen, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv0(0, 0, 0, 0, 0, 0);
    chk("rb_idle", r0_rdy, 0);
    chk("rb_cen", mem_cen, 1);
    chk("rb_no_rvld", r0_rvld, 0);
    step();
    chk("rb_no_rvld2", r0_rvld, 0);
    chk("rb_cen2", mem_cen, 1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mem_arb128.md
# mem_arb128

Two-requester arbiter and sequencer for the 128-bit, 16-byte-lane simulation SRAM bank behind the AXI slave. Requester 0 is the CPU-side AXI slave beat stream; requester 1 is the loader/debug port used for program preload and backdoor inspection. The block holds a grant for a whole burst, drives registered SRAM commands, and returns read data to the owning requester. It optionally snoops console writes.

## Interface
- `AW`, 24: SRAM index width (entries of 16 bytes).
- `MAX_HOLD`, 16: maximum beats per grant before forced release.
- `CONSOLE_ADDR`, 32'h01ff_fff0: console byte address. Used only with the console feature.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rN_vld` in 1, N∈{0,1}: beat request.
- `rN_rdy` out 1: beat accepted when `rN_vld & rN_rdy`.
- `rN_addr` in 32: byte address. Index = `addr[AW+3:4]`; `addr[3:0]` and `addr[31:AW+4]` are ignored (aliasing).
- `rN_we` in 1: 1 = write, 0 = read.
- `rN_wstrb` in 16: byte enables. Bit k covers `wdata[8k+7:8k]`.
- `rN_wdata` in 128: write data.
- `rN_last` in 1: last beat of the burst.
- `rN_rvld` out 1: read response for requester N.
- `rdata` out 128: shared read data.
- `mem_cen` out 1: chip enable, active-low.
- `mem_wen` out 1: write enable, active-low.
- `mem_addr` out AW: SRAM index.
- `mem_bwen` out 16: per-lane write enable, active-low, equal to `~wstrb`.
- `mem_wdata` out 128: SRAM write data.
- `mem_rdata` in 128: SRAM read data, valid 1 cycle after a read command.
- `con_vld` out 1, `con_char` out 8: present only with `MEM_ARB_CONSOLE_EN`.

## Operation
- FSM states are IDLE, GNT0 and GNT1. Reset state is IDLE, with round-robin pointer `rr=0` (requester 0 preferred).
- IDLE:
  - Only one requester asserts vld → go to its GNT.
  - Both assert vld → grant the one `rr` points to.
  - Neither asserts vld → stay in IDLE.
- GNTn:
  - `rn_rdy=1`; the other requester's rdy=0. All rdy outputs are 0 in IDLE.
  - Beat counter increments on each accepted beat.
- Release from GNTn happens on an accepted beat that has `last=1` or is the `MAX_HOLD`-th beat. At release:
  - `rr` moves to the other requester.
  - Next state is the other GNT if the other requester's vld=1 this cycle; otherwise IDLE.
  - There is no bubble on handover.
- The owner dropping vld mid-burst keeps the grant. It idles with no timeout.
- Accepted beat → SRAM command on the next cycle: `mem_cen=0`, `mem_wen=~we`, `mem_addr`, `mem_bwen=~wstrb`, `mem_wdata`.
- A write with `wstrb=0` still issues a command, with all lanes disabled.
- Read response: the owner ID is piped with the command, and `rN_rvld` is asserted 1 cycle after the command with `rdata=mem_rdata`. Responses have no backpressure.

## Timing
- Output reset values: all `rdy=0`, `rvld=0`, `mem_cen=1`, `mem_wen=1`, `mem_bwen=16'hffff`, `mem_addr=0`, `mem_wdata=0`, `con_vld=0`, `con_char=0`.
- Request from IDLE at cycle N → rdy=1 in cycle N+1.
- Accepted at edge E → SRAM command in cycle E+1 → rvld in cycle E+2. Sustained throughput is 1 beat/cycle.
- `rst` mid-burst: the next cycle is IDLE with all outputs at reset values. In-flight commands and read responses are dropped.

## Configuration
- `MEM_ARB_CONSOLE_EN`, when defined: an accepted write with `addr[31:4]==CONSOLE_ADDR[31:4]` pulses `con_vld` for 1 cycle at E+1. `con_char` is selected by strobe:
  - `16'h000f` → `wdata[7:0]`
  - `16'h00f0` → `wdata[39:32]`
  - `16'h0f00` → `wdata[71:64]`
  - `16'hf000` → `wdata[103:96]`
  - Any other strobe → no pulse.
  - The write still reaches the SRAM.
- When undefined: the `con_*` ports and snoop logic are absent, and behaviour is otherwise identical.

## Structure
- `mem_arb_pkg` holds the FSM state enum, `MEM_DW=128`, `MEM_LANES=16`, and the default `CONSOLE_ADDR`.
- Sub-module `mem_arb_con_snoop` contains the strobe decode and char register. It is instantiated only under the macro.

## Test plan
- Single-beat write on r0: addr 0x100, wstrb ffff, data 0x0123…cdef → rdy the cycle after vld; next cycle `mem_addr=0x10`, `mem_wen=0`, `mem_bwen=0`.
- Simultaneous single-beat reads from r0 and r1 after reset → r0 served first, r1 in the next cycle with no bubble. `r0_rvld` and `r1_rvld` follow in consecutive cycles.
- r1 4-beat burst (last on beat 4) while r0 waits → r0_rdy stays 0 for all 4 beats, then r0 is granted the following cycle.
- r0 20-beat write with no last while r1 is pending → released after 16 beats, r1 is served, then r0 regains the grant for beats 17–20.
- Write 0x200 with 0xA5A5…, then read 0x200 → rvld exactly 2 cycles after acceptance with `rdata=0xA5A5…`.
- With the macro: write to 0x01ff_fff0, wstrb 00f0, `wdata[39:32]=0x41` → `con_vld=1`, `con_char=0x41` for one cycle. Assert `rst` on beat 2 of a burst → next cycle IDLE with `mem_cen=1` and no rvld.
